// File: rtl/gray_sobel_router.sv
// Purpose: RGB stream router with an internal grayscale pipeline and an external edge-filter port; modes switch only on frame boundaries.
// Latency: bypass 1 cycle, gray 3 cycles, filter port 2 (gray->filter) or 1 (filter only) cycles, plus 1 cycle after each filter result.
// Backpressure: in_ready_o drops while the pipeline drains between frames; pixels offered then are dropped and set sticky overrun_o.
// Build option: define GRAY_ROUND_EN to round the gray value to nearest instead of truncating.
module gray_sobel_router #(
  parameter int CH_BITS      = 8,
  parameter int FRAME_PIXELS = 64
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [1:0]           select_i,
  input  logic                 px_valid_i,
  input  logic [3*CH_BITS-1:0] in_pixel_i,
  output logic                 in_ready_o,
  output logic [3*CH_BITS-1:0] out_pixel_o,
  output logic                 out_valid_o,
  output logic                 flt_valid_o,
  output logic [CH_BITS-1:0]   flt_pixel_o,
  input  logic                 flt_valid_i,
  input  logic [CH_BITS-1:0]   flt_pixel_i,
  input  logic                 flt_busy_i,
  output logic [1:0]           active_mode_o,
  output logic                 overrun_o
);

  localparam int PW    = 3 * CH_BITS;
  // Wide enough for 256*max_channel + 128 and for 2*CH_BITS+1.
  localparam int SUM_W = (2 * CH_BITS + 1 > CH_BITS + 9) ? 2 * CH_BITS + 1 : CH_BITS + 9;
  localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  localparam logic [1:0] M_GRAY_FLT = 2'b00;
  localparam logic [1:0] M_FLT      = 2'b01;
  localparam logic [1:0] M_GRAY     = 2'b10;
  localparam logic [1:0] M_BYPASS   = 2'b11;

`ifdef GRAY_ROUND_EN
  localparam logic [SUM_W-1:0] RND_TERM = SUM_W'(128);
`else
  localparam logic [SUM_W-1:0] RND_TERM = '0;
`endif

  typedef enum logic {RUN, DRAIN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   pix_cnt;
  logic               accept;
  logic               use_gray;
  logic               frame_end;
  logic               pipe_empty;

  logic               g1_vld;
  logic [SUM_W-1:0]   p_r, p_g, p_b;
  logic [SUM_W-1:0]   gray_sum;
  logic               g2_vld;
  logic [CH_BITS-1:0] g2_dat;
  logic               fin_vld;
  logic [CH_BITS-1:0] fin_dat;

  logic [CH_BITS-1:0] ch_r, ch_g, ch_b;

  assign ch_r = in_pixel_i[PW-1 -: CH_BITS];
  assign ch_g = in_pixel_i[2*CH_BITS-1 -: CH_BITS];
  assign ch_b = in_pixel_i[CH_BITS-1:0];

  assign accept    = px_valid_i && in_ready_o;
  // Modes 00 and 10 feed the gray pipeline; the others leave it idle so
  // a drain from bypass or filter-only mode does not wait on it.
  assign use_gray  = (active_mode_o[0] == 1'b0);
  assign frame_end = accept && (pix_cnt == LAST_IDX);
  assign pipe_empty = !g1_vld && !g2_vld && !fin_vld && !flt_busy_i;
  assign gray_sum  = p_r + p_g + p_b + RND_TERM;

  // G1: register the three weighted channel products
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      g1_vld <= 1'b0;
      p_r    <= '0;
      p_g    <= '0;
      p_b    <= '0;
    end else begin
      g1_vld <= accept && use_gray;
      if (accept && use_gray) begin
        p_r <= SUM_W'(ch_r) * SUM_W'(77);
        p_g <= SUM_W'(ch_g) * SUM_W'(150);
        p_b <= SUM_W'(ch_b) * SUM_W'(29);
      end
    end
  end

  // G2: register the summed, shifted gray value
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      g2_vld <= 1'b0;
      g2_dat <= '0;
    end else begin
      g2_vld <= g1_vld;
      if (g1_vld) begin
        g2_dat <= CH_BITS'(gray_sum >> 8);
      end
    end
  end

  // Filter-input register for filter-only mode (blue channel)
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fin_vld <= 1'b0;
      fin_dat <= '0;
    end else begin
      fin_vld <= accept && (active_mode_o == M_FLT);
      if (accept && (active_mode_o == M_FLT)) begin
        fin_dat <= ch_b;
      end
    end
  end

  // Steer the filter-engine input from gray or raw registered data
  always_comb begin
    flt_valid_o = 1'b0;
    flt_pixel_o = '0;
    case (active_mode_o)
      M_GRAY_FLT: begin
        flt_valid_o = g2_vld;
        flt_pixel_o = g2_dat;
      end
      M_FLT: begin
        flt_valid_o = fin_vld;
        flt_pixel_o = fin_dat;
      end
      default: begin
        flt_valid_o = 1'b0;
        flt_pixel_o = '0;
      end
    endcase
  end

  // Output register: select the result source for the active mode
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_valid_o <= 1'b0;
      out_pixel_o <= '0;
    end else begin
      out_valid_o <= 1'b0;
      case (active_mode_o)
        M_BYPASS: begin
          if (accept) begin
            out_valid_o <= 1'b1;
            out_pixel_o <= in_pixel_i;
          end
        end
        M_GRAY: begin
          if (g2_vld) begin
            out_valid_o <= 1'b1;
            out_pixel_o <= {{(PW-CH_BITS){1'b0}}, g2_dat};
          end
        end
        default: begin
          if (flt_valid_i) begin
            out_valid_o <= 1'b1;
            out_pixel_o <= {{(PW-CH_BITS){1'b0}}, flt_pixel_i};
          end
        end
      endcase
    end
  end

  // Frame counter: index of the next accepted pixel within the frame
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pix_cnt <= '0;
    end else if (accept) begin
      pix_cnt <= (pix_cnt == LAST_IDX) ? '0 : pix_cnt + CNT_W'(1);
    end
  end

  // FSM state register; reset lands in DRAIN so the first mode is taken from select_i
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= DRAIN;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: drain only at a frame boundary with a pending mode change
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (frame_end && (select_i != active_mode_o)) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = RUN;
      default: state_nxt = DRAIN;
    endcase
  end

  // FSM outputs: input is accepted only in RUN
  always_comb begin
    in_ready_o = (state == RUN);
  end

  // Apply the mode sampled on the cycle the drain completes
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active_mode_o <= M_BYPASS;
    end else if ((state == DRAIN) && pipe_empty) begin
      active_mode_o <= select_i;
    end
  end

  // Sticky flag for pixels offered while not ready
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overrun_o <= 1'b0;
    end else if (px_valid_i && !in_ready_o) begin
      overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gray_sobel_router.sv
// Scoreboard bench for gray_sobel_router with a 4-pixel frame and a latency-5 stub filter engine.
module tb_gray_sobel_router;

  localparam int FP = 4;

`ifdef GRAY_ROUND_EN
  localparam logic [23:0] G_C = 24'd1;
  localparam logic [23:0] G_D = 24'd29;
`else
  localparam logic [23:0] G_C = 24'd0;
  localparam logic [23:0] G_D = 24'd28;
`endif

  // Pixel table {R,G,B}
  localparam logic [23:0] PX_A = 24'hFFFFFF;  // gray 255
  localparam logic [23:0] PX_B = 24'h6432C8;  // (100,50,200) gray 82
  localparam logic [23:0] PX_C = 24'h020000;  // (2,0,0) gray 0 / 1
  localparam logic [23:0] PX_D = 24'h0000FF;  // (0,0,255) gray 28 / 29
  localparam logic [23:0] PX_E = 24'h0A141E;  // (10,20,30) gray 18
  localparam logic [23:0] PX_F = 24'h00FF00;  // (0,255,0) gray 149
  localparam logic [23:0] PX_G = 24'hFF0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  sel = 2'b10;
  logic        px_valid = 1'b0;
  logic [23:0] in_pixel = '0;
  logic        in_ready;
  logic [23:0] out_pixel;
  logic        out_valid;
  logic        flt_valid_o;
  logic [7:0]  flt_pixel_o;
  logic        flt_valid_i;
  logic [7:0]  flt_pixel_i;
  logic        flt_busy;
  logic [1:0]  active_mode;
  logic        overrun;
  logic        busy_hold = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [23:0] sb[$];

  always #5 clk = ~clk;

  gray_sobel_router #(.CH_BITS(8), .FRAME_PIXELS(FP)) dut (
    .clk_i(clk), .reset_i(reset), .select_i(sel), .px_valid_i(px_valid),
    .in_pixel_i(in_pixel), .in_ready_o(in_ready), .out_pixel_o(out_pixel),
    .out_valid_o(out_valid), .flt_valid_o(flt_valid_o), .flt_pixel_o(flt_pixel_o),
    .flt_valid_i(flt_valid_i), .flt_pixel_i(flt_pixel_i), .flt_busy_i(flt_busy),
    .active_mode_o(active_mode), .overrun_o(overrun)
  );

  // Stub filter engine: 5-cycle pipe, result = input ^ 8'hA5
  logic [4:0]      st_v;
  logic [4:0][7:0] st_d;
  always @(posedge clk) begin
    if (reset) st_v <= '0;
    else st_v <= {st_v[3:0], flt_valid_o};
    st_d <= {st_d[3:0], flt_pixel_o ^ 8'hA5};
  end
  assign flt_valid_i = st_v[4];
  assign flt_pixel_i = st_d[4];
  assign flt_busy    = (|st_v) | busy_hold;

  logic fvi_d = 1'b0;
  always @(posedge clk) fvi_d <= reset ? 1'b0 : flt_valid_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop the scoreboard on every output pulse
  always @(negedge clk) begin
    logic [23:0] e;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_unexpected: got out_pixel_o=%h, required no output (t=%0t)", out_pixel, $time);
      end else begin
        e = sb.pop_front();
        chk("out_pixel", out_pixel, e);
      end
    end
    if (active_mode[1] == 1'b0 && (fvi_d || out_valid))
      chk("out_after_flt", out_valid, fvi_d);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] pix, input logic [23:0] exp, input bit push, output int stall);
    stall = 0;
    px_valid = 1'b1;
    in_pixel = pix;
    while (in_ready !== 1'b1 && stall < 40) begin
      tick();
      stall++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: in_ready_o=%b, required 1", in_ready);
    end else if (push) begin
      sb.push_back(exp);
    end
    tick();
    px_valid = 1'b0;
  endtask

  task automatic wait_ready(input int maxc, output int n);
    n = 0;
    while (in_ready !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: in_ready_o=%b, required 1", in_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int st;
    int n;
    bit saw_ready;

    // Reset state and startup into mode 10
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_active_mode", active_mode, 2'b11);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_flt_valid", flt_valid_o, 0);
    chk("rst_flt_pixel", flt_pixel_o, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    chk("start_ready_c1", in_ready, 0);
    tick();
    chk("start_ready_c2", in_ready, 1);
    chk("start_mode", active_mode, 2'b10);

    // Frame 1, mode 10: gray arithmetic and 3-cycle latency
    send(PX_A, 24'h0000FF, 1, st);
    chk("g_lat_c1", out_valid, 0);
    tick();
    chk("g_lat_c2", out_valid, 0);
    tick();
    chk("g_lat_c3", out_valid, 1);
    chk("g_lat_c3_pix", out_pixel, 24'h0000FF);
    send(PX_B, 24'd82, 1, st);
    send(PX_C, G_C, 1, st);
    send(PX_D, G_D, 1, st);
    chk("no_bubble_same_mode", in_ready, 1);

    // Frame 2, mode 10, request 00 mid-frame: 3-cycle drain from gray mode
    send(PX_E, 24'd18, 1, st);
    sel = 2'b00;
    send(PX_F, 24'd149, 1, st);
    chk("midframe_no_effect", active_mode, 2'b10);
    send(PX_A, 24'd255, 1, st);
    send(PX_B, 24'd82, 1, st);
    chk("drain_entered", in_ready, 0);
    wait_ready(40, n);
    chk("drain_len_gray", n, 3);
    chk("mode_00", active_mode, 2'b00);

    // Frame 3, mode 00: gray result to the filter at cycle 2
    send(PX_B, 24'h0000F7, 1, st);
    chk("m00_flt_c1", flt_valid_o, 0);
    tick();
    chk("m00_flt_c2", flt_valid_o, 1);
    chk("m00_flt_pix", flt_pixel_o, 8'd82);
    send(PX_E, 24'h0000B7, 1, st);
    sel = 2'b01;
    send(PX_A, 24'h00005A, 1, st);
    send(PX_F, 24'h000030, 1, st);
    wait_ready(40, n);
    chk("mode_01", active_mode, 2'b01);

    // Frame 4, mode 01: raw blue channel to the filter at cycle 1
    send(PX_B, 24'h00006D, 1, st);
    chk("m01_flt_c1", flt_valid_o, 1);
    chk("m01_flt_pix", flt_pixel_o, 8'hC8);
    sel = 2'b11;
    send(PX_E, 24'h0000BB, 1, st);
    send(PX_A, 24'h00005A, 1, st);
    send(PX_F, 24'h0000A5, 1, st);
    busy_hold = 1'b1;
    saw_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0) saw_ready = 1'b1;
      tick();
    end
    chk("ready_low_while_busy", saw_ready, 0);
    busy_hold = 1'b0;
    wait_ready(40, n);
    chk("drain_exit_after_busy", n, 1);
    chk("flt_results_before_m11", sb.size(), 0);
    chk("mode_11", active_mode, 2'b11);

    // Frame 5, mode 11: bypass at cycle 1
    send(PX_A, PX_A, 1, st);
    chk("m11_lat_c1", out_valid, 1);
    chk("m11_lat_pix", out_pixel, PX_A);
    send(PX_B, PX_B, 1, st);
    send(PX_E, PX_E, 1, st);
    send(PX_F, PX_F, 1, st);
    chk("m11_no_bubble", in_ready, 1);
    chk("overrun_clear", overrun, 0);

    // Frame 6, continuous stream: 11 -> 10 switch requested after pixel 1
    send(PX_G, PX_G, 1, st);
    send(PX_C, PX_C, 1, st);
    sel = 2'b10;
    send(PX_D, PX_D, 1, st);
    send(PX_A, PX_A, 1, st);
    send(PX_B, 24'd82, 1, st);
    chk("drain_len_bypass", st, 1);
    chk("mode_10_after_switch", active_mode, 2'b10);
    chk("overrun_set", overrun, 1);
    repeat (5) tick();

    // Reset after two more pixels in mode 10: nothing may come out
    send(PX_E, 24'd0, 0, st);
    send(PX_F, 24'd0, 0, st);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst2_ready", in_ready, 1);
    chk("rst2_overrun", overrun, 0);
    chk("rst2_mode", active_mode, 2'b10);
    send(PX_B, 24'd82, 1, st);
    sel = 2'b11;
    send(PX_E, 24'd18, 1, st);
    send(PX_A, 24'd255, 1, st);
    chk("rst2_cnt_px2_run", in_ready, 1);
    send(PX_F, 24'd149, 1, st);
    chk("rst2_cnt_px3_drain", in_ready, 0);
    wait_ready(40, n);
    chk("rst2_drain_len", n, 3);
    chk("rst2_mode_11", active_mode, 2'b11);

    repeat (10) tick();
    chk("sb_empty_end", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
